bnn_seq_ctrl: RTL and testbench

- Sequencer for the serial BNN inference datapath: one XNOR-popcount neuron engine is time-shared across all hidden neurons, then all class neurons.
- Accepts one feature vector per inference through a valid/ready handshake and latches it.
- Issues one neuron evaluation per dp_start/dp_done handshake and collects the signed sums: hidden sums are binarised into hidden_bits, class sums go to a running argmax.
- Returns the predicted class through a valid/ready handshake. A watchdog aborts the inference if the datapath stalls.

---
 rtl/bnn_seq_ctrl_pkg.sv | 40 ++++
 rtl/bnn_seq_ctrl_argmax_tracker.sv | 42 ++++
 rtl/bnn_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bnn_seq_pkg
// Purpose  : Shared types and width helpers for the BNN inference sequencer.
//            Holds the controller state encoding, index/prediction width
//            helpers and the default signed-sum width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bnn_seq_pkg;

    localparam int DEFAULT_SUM_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // $clog2 returns 0 for a count of 1; a zero-width bus is not legal.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Neuron index must cover whichever layer is larger.
    function automatic int IDX_W(input int hidden_cnt, input int class_cnt);
        int h_w;
        int c_w;
        h_w = clog2_min1(hidden_cnt);
        c_w = clog2_min1(class_cnt);
        return (h_w > c_w) ? h_w : c_w;
    endfunction

    function automatic int PRED_W(input int class_cnt);
        return clog2_min1(class_cnt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_seq_ctrl_argmax_tracker.sv
`default_nettype none
// ============================================================================
// Module   : argmax_tracker
// Purpose  : Running signed argmax over the class-neuron sums. Index 0 always
//            loads; later indices replace the best only when strictly
//            greater, so ties resolve to the lowest index.
// Ports    : clk, rst (sync, active-low)
//            clear            - restart tracking for a new inference
//            valid            - value/index pair presented this cycle
//            value [SUM_BITS] - signed class sum
//            index [IDX_BITS] - class index of value
//            best_idx/best_sum- current winner
// Revision : 1.0 - initial release
// ============================================================================
module argmax_tracker
    import bnn_seq_pkg::*;
#(
    parameter int IDX_BITS = 3,
    parameter int SUM_BITS = DEFAULT_SUM_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       valid,
    input  logic signed [SUM_BITS-1:0] value,
    input  logic        [IDX_BITS-1:0] index,
    output logic        [IDX_BITS-1:0] best_idx,
    output logic signed [SUM_BITS-1:0] best_sum
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            best_idx <= '0;
            best_sum <= '0;
        end else if (valid && ((index == '0) || (value > best_sum))) begin
            best_idx <= index;
            best_sum <= value;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bnn_seq_ctrl
// Purpose  : Sequencer for the serial BNN datapath. Latches one feature
//            vector, issues every hidden neuron then every class neuron to a
//            shared XNOR-popcount engine, binarises hidden sums, tracks the
//            class argmax and returns the predicted class. A watchdog aborts
//            the inference when the engine stalls.
// Ports    : clk, rst (sync, active-low)
//            in_valid/in_ready/features      - feature vector handshake
//            dp_features/dp_layer/dp_idx     - neuron request to datapath
//            dp_start/dp_done/dp_sum         - per-neuron handshake and sum
//            hidden_bits                     - binarised hidden activations
//            out_valid/out_ready/prediction  - result handshake
//            timeout_err                     - last inference aborted
// Revision : 1.0 - initial release
// ============================================================================
module bnn_seq_ctrl
    import bnn_seq_pkg::*;
#(
    parameter int FEAT_CNT   = 128,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int SUM_BITS   = DEFAULT_SUM_BITS,
    parameter int TIMEOUT    = 255
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]               features,
    output logic [FEAT_CNT*FEAT_BITS-1:0]               dp_features,
    output logic                                        dp_layer,
    output logic [IDX_W(HIDDEN_CNT, CLASS_CNT)-1:0]     dp_idx,
    output logic                                        dp_start,
    input  logic                                        dp_done,
    input  logic signed [SUM_BITS-1:0]                  dp_sum,
    output logic [HIDDEN_CNT-1:0]                       hidden_bits,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [PRED_W(CLASS_CNT)-1:0]                prediction,
    output logic                                        timeout_err
);

    localparam int IDX_BITS  = IDX_W(HIDDEN_CNT, CLASS_CNT);
    localparam int PRED_BITS = PRED_W(CLASS_CNT);
    localparam int WD_BITS   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_BITS-1:0] LAST_HIDDEN = IDX_BITS'(HIDDEN_CNT - 1);
    localparam logic [IDX_BITS-1:0] LAST_CLASS  = IDX_BITS'(CLASS_CNT - 1);
    // Abort fires on the TIMEOUT-th WAIT cycle; the counter starts at 0.
    localparam logic [WD_BITS-1:0]  WD_LAST     = WD_BITS'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_BITS-1:0]  WD_MAX      = WD_BITS'(TIMEOUT);

    state_t                          r_state;
    state_t                          w_state_next;
    logic                            r_layer;
    logic [IDX_BITS-1:0]             r_idx;
    logic [WD_BITS-1:0]              r_wd_cnt;
    logic [FEAT_CNT*FEAT_BITS-1:0]   r_features;
    logic [HIDDEN_CNT-1:0]           r_hidden;
    logic [PRED_BITS-1:0]            r_pred;
    logic                            r_timeout_err;

    logic                            w_accept;
    logic                            w_neuron_done;
    logic                            w_timeout;
    logic                            w_wd_hit;
    logic                            w_last_hidden;
    logic                            w_last_class;
    logic                            w_class_take;
    logic [PRED_BITS-1:0]            w_best_idx;
    logic signed [SUM_BITS-1:0]      w_best_sum;

    assign w_last_hidden = !r_layer && (r_idx == LAST_HIDDEN);
    assign w_last_class  =  r_layer && (r_idx == LAST_CLASS);
    assign w_wd_hit      = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);

    // The tracker only registers the last class sum on the same edge that
    // enters DONE, so the final winner is resolved here from the same rule.
    assign w_class_take  = (r_idx == '0) || (dp_sum > w_best_sum);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        dp_start      = 1'b0;
        w_accept      = 1'b0;
        w_neuron_done = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                dp_start     = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (dp_done) begin
                    w_neuron_done = 1'b1;
                    w_state_next  = w_last_class ? DONE : ISSUE;
                end else if (w_wd_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_layer       <= 1'b0;
            r_idx         <= '0;
            r_wd_cnt      <= '0;
            r_features    <= '0;
            r_hidden      <= '0;
            r_pred        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_features    <= features;
                r_hidden      <= '0;
                r_timeout_err <= 1'b0;
                r_layer       <= 1'b0;
                r_idx         <= '0;
            end

            if (r_state == ISSUE) begin
                r_wd_cnt <= '0;
            end else if ((r_state == WAIT) && (r_wd_cnt != WD_MAX)) begin
                r_wd_cnt <= r_wd_cnt + WD_BITS'(1);
            end

            if (w_neuron_done) begin
                if (!r_layer) begin
                    // Sign bit clear means sum >= 0, which binarises to 1.
                    r_hidden[r_idx] <= ~dp_sum[SUM_BITS-1];
                end
                if (w_last_hidden) begin
                    r_layer <= 1'b1;
                    r_idx   <= '0;
                end else if (w_last_class) begin
                    r_pred  <= w_class_take ? r_idx[PRED_BITS-1:0] : w_best_idx;
                end else begin
                    r_idx   <= r_idx + IDX_BITS'(1);
                end
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_pred        <= '0;
            end
        end
    end

    argmax_tracker #(
        .IDX_BITS (PRED_BITS),
        .SUM_BITS (SUM_BITS)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_accept),
        .valid    (w_neuron_done && r_layer),
        .value    (dp_sum),
        .index    (r_idx[PRED_BITS-1:0]),
        .best_idx (w_best_idx),
        .best_sum (w_best_sum)
    );

    // Layer select is forced low outside an active neuron request.
    assign dp_layer    = r_layer && ((r_state == ISSUE) || (r_state == WAIT));
    assign dp_idx      = r_idx;
    assign dp_features = r_features;
    assign hidden_bits = r_hidden;
    assign prediction  = r_pred;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_bnn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_seq_ctrl
// Purpose  : Directed self-checking bench for bnn_seq_ctrl. Instance A uses
//            the default parameters, instance B uses TIMEOUT=8; a select
//            signal routes the shared stimulus to one of them. A small
//            datapath model answers each dp_start with the scripted sum.
// Ports    : none (testbench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bnn_seq_ctrl;

    localparam int H  = 40;
    localparam int C  = 6;
    localparam int FW = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, sel, in_valid, dp_done, out_ready;
    logic [FW-1:0]       features;
    logic signed [15:0]  dp_sum;

    logic                in_ready_a, dp_layer_a, dp_start_a, out_valid_a, timeout_err_a;
    logic [FW-1:0]       dp_features_a;
    logic [5:0]          dp_idx_a;
    logic [H-1:0]        hidden_bits_a;
    logic [2:0]          prediction_a;
    logic                in_ready_b, dp_layer_b, dp_start_b, out_valid_b, timeout_err_b;
    logic [FW-1:0]       dp_features_b;
    logic [5:0]          dp_idx_b;
    logic [H-1:0]        hidden_bits_b;
    logic [2:0]          prediction_b;

    logic in_valid_a, in_valid_b, dp_done_a, dp_done_b, out_ready_a, out_ready_b;
    assign in_valid_a  = in_valid  & ~sel;
    assign in_valid_b  = in_valid  &  sel;
    assign dp_done_a   = dp_done   & ~sel;
    assign dp_done_b   = dp_done   &  sel;
    assign out_ready_a = out_ready & ~sel;
    assign out_ready_b = out_ready &  sel;

    logic          m_in_ready, m_dp_layer, m_dp_start, m_out_valid, m_timeout_err;
    logic [FW-1:0] m_dp_features;
    logic [5:0]    m_dp_idx;
    logic [H-1:0]  m_hidden_bits;
    logic [2:0]    m_prediction;
    assign m_in_ready    = sel ? in_ready_b    : in_ready_a;
    assign m_dp_layer    = sel ? dp_layer_b    : dp_layer_a;
    assign m_dp_start    = sel ? dp_start_b    : dp_start_a;
    assign m_out_valid   = sel ? out_valid_b   : out_valid_a;
    assign m_timeout_err = sel ? timeout_err_b : timeout_err_a;
    assign m_dp_features = sel ? dp_features_b : dp_features_a;
    assign m_dp_idx      = sel ? dp_idx_b      : dp_idx_a;
    assign m_hidden_bits = sel ? hidden_bits_b : hidden_bits_a;
    assign m_prediction  = sel ? prediction_b  : prediction_a;

    bnn_seq_ctrl u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .features(features), .dp_features(dp_features_a), .dp_layer(dp_layer_a),
        .dp_idx(dp_idx_a), .dp_start(dp_start_a), .dp_done(dp_done_a), .dp_sum(dp_sum),
        .hidden_bits(hidden_bits_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .prediction(prediction_a), .timeout_err(timeout_err_a)
    );

    bnn_seq_ctrl #(.TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .features(features), .dp_features(dp_features_b), .dp_layer(dp_layer_b),
        .dp_idx(dp_idx_b), .dp_start(dp_start_b), .dp_done(dp_done_b), .dp_sum(dp_sum),
        .hidden_bits(hidden_bits_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .prediction(prediction_b), .timeout_err(timeout_err_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [15:0] hsum [H];
    logic signed [15:0] csum [C];
    logic [FW-1:0]      feat, feat2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_feat(input string tag, input logic [FW-1:0] exp);
        n_cmp++;
        assert (m_dp_features === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, m_dp_features, exp);
        end
    endtask

    // Returns at the falling edge of cycle 1 (first ISSUE cycle).
    task automatic do_accept(input logic [FW-1:0] f);
        @(negedge clk);
        features = f;
        in_valid = 1'b1;
        chk("accept_in_ready", m_in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_feat("accept_dp_features", f);
    endtask

    // Called at a falling edge while the controller is in DONE.
    task automatic do_release();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", m_out_valid, 0);
        chk("release_in_ready", m_in_ready, 1);
    endtask

    // Datapath model, evaluated once per falling edge starting at cycle 1.
    // A neuron's sum is returned 1..max_d cycles after its dp_start.
    task automatic service(input int max_d, input bit spur, input int hold_n,
                           input int abort_n, output int out_cyc, output int hold_cyc);
        int  cyc, n, cd;
        bit  pending, aborted;
        logic signed [15:0] val;
        cyc = 1; n = 0; cd = 0; pending = 0; aborted = 0; val = '0;
        out_cyc = -1; hold_cyc = -1;
        while (cyc < 3000) begin
            dp_done = 1'b0;
            if (pending) begin
                if (cd == 0) begin
                    dp_done = 1'b1;
                    dp_sum  = val;
                    pending = 0;
                end else begin
                    cd--;
                end
            end
            if (m_out_valid) begin
                out_cyc = cyc;
                break;
            end
            chk("busy_in_ready", m_in_ready, 0);
            if (m_dp_start) begin
                chk("seq_layer", m_dp_layer, (n >= H) ? 1 : 0);
                chk("seq_idx", m_dp_idx, (n >= H) ? n - H : n);
                if (n == abort_n) begin
                    aborted = 1;
                    break;
                end
                if (n == hold_n) begin
                    hold_cyc = cyc;
                end else begin
                    pending = 1;
                    cd      = (max_d > 1) ? int'($urandom_range(max_d - 1, 0)) : 0;
                    val     = (n < H) ? hsum[n] : csum[n - H];
                end
                if (spur && ($urandom_range(2, 0) == 0)) begin
                    dp_done = 1'b1;
                    dp_sum  = 16'sh7fff;
                end
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        dp_done = 1'b0;
        n_cmp++;
        assert (out_cyc >= 0 || aborted) else begin
            n_fail++;
            $error("FAIL service_budget: observed no out_valid after %0d cycles, expected completion", cyc);
        end
    endtask

    int oc, hc;

    initial begin
        rst = 1'b0; sel = 1'b0; in_valid = 1'b0; dp_done = 1'b0; out_ready = 1'b0;
        features = '0; dp_sum = '0;
        for (int i = 0; i < 16; i++) feat[i*32 +: 32] = $urandom;
        feat2 = ~feat;
        for (int i = 0; i < H; i++) hsum[i] = (i % 2 == 0) ? 16'sd5 : -16'sd3;
        csum = '{16'sd2, -16'sd7, 16'sd9, 16'sd4, 16'sd9, 16'sd0};

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_dp_start", dp_start_a, 0);
        chk("rst_dp_layer", dp_layer_a, 0);
        chk("rst_dp_idx", dp_idx_a, 0);
        chk("rst_hidden", hidden_bits_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_prediction", prediction_a, 0);
        chk("rst_timeout", timeout_err_a, 0);
        chk_feat("rst_dp_features", '0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_dp_start", dp_start_a, 0);
            chk("idle_in_ready", in_ready_a, 1);
        end

        // Nominal single-cycle datapath
        do_accept(feat);
        service(1, 0, -1, -1, oc, hc);
        chk("nom_cycle", oc, 93);
        chk("nom_hidden", m_hidden_bits, 40'h55_5555_5555);
        chk("nom_pred", m_prediction, 2);
        chk("nom_timeout", m_timeout_err, 0);
        chk("nom_done_layer", m_dp_layer, 0);
        do_release();

        // Variable latency, spurious done pulses, output backpressure
        do_accept(feat2);
        service(20, 1, -1, -1, oc, hc);
        chk("var_hidden", m_hidden_bits, 40'h55_5555_5555);
        chk("var_pred", m_prediction, 2);
        for (int i = 0; i < 10; i++) begin
            dp_done = (i == 3);
            dp_sum  = 16'sh7fff;
            @(negedge clk);
            chk("bp_pred", m_prediction, 2);
            chk("bp_out_valid", m_out_valid, 1);
            chk("bp_in_ready", m_in_ready, 0);
        end
        dp_done = 1'b0;
        chk("bp_hidden", m_hidden_bits, 40'h55_5555_5555);
        do_release();

        // Watchdog on the TIMEOUT=8 instance
        sel = 1'b1;
        do_accept(feat);
        service(1, 0, 3, -1, oc, hc);
        chk("wd_hold_cycle", hc, 7);
        chk("wd_abort_cycle", oc, 16);
        chk("wd_timeout", m_timeout_err, 1);
        chk("wd_pred", m_prediction, 0);
        chk("wd_hidden", m_hidden_bits, 40'h5);
        chk("wd_done_layer", m_dp_layer, 0);
        do_release();
        do_accept(feat2);
        chk("wd_clear_timeout", m_timeout_err, 0);
        service(1, 0, -1, -1, oc, hc);
        chk("wd_clean_cycle", oc, 93);
        chk("wd_clean_pred", m_prediction, 2);
        chk("wd_clean_timeout", m_timeout_err, 0);
        do_release();
        sel = 1'b0;

        // Reset while waiting on class neuron 2
        do_accept(feat);
        service(1, 0, -1, H + 2, oc, hc);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_in_ready", m_in_ready, 1);
        chk("mid_out_valid", m_out_valid, 0);
        chk("mid_hidden", m_hidden_bits, 0);
        chk("mid_dp_start", m_dp_start, 0);
        chk("mid_dp_layer", m_dp_layer, 0);
        chk("mid_dp_idx", m_dp_idx, 0);
        rst = 1'b1;
        do_accept(feat2);
        service(1, 0, -1, -1, oc, hc);
        chk("post_rst_cycle", oc, 93);
        chk("post_rst_pred", m_prediction, 2);
        chk("post_rst_hidden", m_hidden_bits, 40'h55_5555_5555);
        do_release();

        // All-negative class sums, then back-to-back with in_valid held
        csum = '{-16'sd1, -16'sd9, -16'sd1, -16'sd4, -16'sd2, -16'sd8};
        do_accept(feat);
        service(1, 0, -1, -1, oc, hc);
        chk("neg_cycle", oc, 93);
        chk("neg_pred", m_prediction, 0);
        csum = '{-16'sd5, -16'sd3, -16'sd3, -16'sd9, -16'sd6, -16'sd4};
        features  = feat2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_out_valid", m_out_valid, 0);
        chk("b2b_idle_in_ready", m_in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accept_in_ready", m_in_ready, 0);
        chk("b2b_accept_dp_start", m_dp_start, 1);
        chk_feat("b2b_dp_features", feat2);
        service(1, 0, -1, -1, oc, hc);
        chk("b2b_cycle", oc, 93);
        chk("b2b_pred", m_prediction, 1);
        do_release();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
